// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the non-restoring divider
package div_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_nr_param_if.sv
// rtl/div_nr_param_if.sv - multdiv-style divide handshake bundle (data_remainder under DIV_REMAINDER_EN)
interface div_nr_param_if
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             ctrl_DIV;
    logic             ctrl_MULT;
    logic             is_signed;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
`ifdef DIV_REMAINDER_EN
    logic [WIDTH-1:0] data_remainder;
`endif
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
`ifdef DIV_REMAINDER_EN
        input  data_remainder,
`endif
        output ctrl_DIV, ctrl_MULT, is_signed, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
`ifdef DIV_REMAINDER_EN
        output data_remainder,
`endif
        input  ctrl_DIV, ctrl_MULT, is_signed, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );

endinterface

// File: rtl/div_nr_step.sv
// rtl/div_nr_step.sv - one combinational non-restoring divide iteration
module div_nr_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_p,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bit,
    output logic [WIDTH:0]   o_p,
    output logic             o_q
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_b_ext;

    // The intermediate shift may wrap in WIDTH+1 bits; the true result always fits.
    assign w_shift = {i_p[WIDTH-1:0], i_bit};
    assign w_b_ext = {1'b0, i_b};
    assign o_p     = i_p[WIDTH] ? (w_shift + w_b_ext) : (w_shift - w_b_ext);
    assign o_q     = ~o_p[WIDTH];

endmodule

// File: rtl/div_nr_param.sv
// rtl/div_nr_param.sv - iterative signed/unsigned divider, remainder output with DIV_REMAINDER_EN
module div_nr_param
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic          clock,
    input  logic          reset,
    div_nr_param_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_p;
    logic [WIDTH-1:0] r_q, r_b, r_result;
    logic             r_sa, r_sb, r_exc, r_rdy;

    logic             w_start, w_zero, w_a_neg, w_b_neg;
    logic             w_busy, w_step_en, w_fix_en, w_rdy_set;
    logic [WIDTH-1:0] w_a_mag, w_b_mag, w_q_fix;
    logic [WIDTH:0]   w_step_p;
    logic             w_step_q;

    assign w_start = bus.ctrl_DIV & ~bus.ctrl_MULT;
    assign w_zero  = (bus.data_operandB == '0);
    assign w_a_neg = bus.is_signed & bus.data_operandA[WIDTH-1];
    assign w_b_neg = bus.is_signed & bus.data_operandB[WIDTH-1];
    // |MIN| wraps to 2^(WIDTH-1), which is exactly the unsigned magnitude we want.
    assign w_a_mag = w_a_neg ? -bus.data_operandA : bus.data_operandA;
    assign w_b_mag = w_b_neg ? -bus.data_operandB : bus.data_operandB;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (bus.ctrl_MULT) begin
            w_next = IDLE;
        end else if (bus.ctrl_DIV) begin
            w_next = w_zero ? DONE : RUN;
        end else begin
            case (r_state)
                RUN:     if (r_cnt == CW'(1)) w_next = FIX;
                FIX:     w_next = DONE;
                DONE:    w_next = IDLE;
                default: w_next = r_state;
            endcase
        end
    end

    always_comb begin
        w_busy    = 1'b0;
        w_step_en = 1'b0;
        w_fix_en  = 1'b0;
        w_rdy_set = 1'b0;
        case (r_state)
            RUN: begin
                w_busy    = 1'b1;
                w_step_en = ~bus.ctrl_MULT & ~bus.ctrl_DIV;
            end
            FIX: begin
                w_busy   = 1'b1;
                w_fix_en = ~bus.ctrl_MULT & ~bus.ctrl_DIV;
            end
            DONE:    w_rdy_set = ~bus.ctrl_MULT & ~bus.ctrl_DIV;
            default: w_busy = 1'b0;
        endcase
    end

    div_nr_step #(.WIDTH(WIDTH)) u_step (
        .i_p   (r_p),
        .i_b   (r_b),
        .i_bit (r_q[WIDTH-1]),
        .o_p   (w_step_p),
        .o_q   (w_step_q)
    );

    assign w_q_fix = (r_sa ^ r_sb) ? -r_q : r_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_p      <= '0;
            r_q      <= '0;
            r_b      <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            r_rdy <= w_rdy_set;
            if (w_start) begin
                r_cnt <= CW'(WIDTH);
                r_p   <= '0;
                r_q   <= w_a_mag;
                r_b   <= w_b_mag;
                r_sa  <= w_a_neg;
                r_sb  <= w_b_neg;
                if (w_zero) begin
                    r_result <= '0;
                    r_exc    <= 1'b1;
                end
            end else if (w_step_en) begin
                r_cnt <= r_cnt - CW'(1);
                r_p   <= w_step_p;
                r_q   <= {r_q[WIDTH-2:0], w_step_q};
            end else if (w_fix_en) begin
                r_result <= w_q_fix;
                r_exc    <= 1'b0;
            end
        end
    end

`ifdef DIV_REMAINDER_EN
    logic [WIDTH:0]   w_p_corr;
    logic [WIDTH-1:0] w_rem_fix, r_rem;

    assign w_p_corr  = r_p[WIDTH] ? (r_p + {1'b0, r_b}) : r_p;
    assign w_rem_fix = r_sa ? -w_p_corr[WIDTH-1:0] : w_p_corr[WIDTH-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                 r_rem <= '0;
        else if (w_start && w_zero) r_rem <= bus.data_operandA;
        else if (w_fix_en)          r_rem <= w_rem_fix;
    end

    assign bus.data_remainder = r_rem;
`endif

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = r_rdy;
    assign bus.busy           = w_busy;

endmodule

// File: tb/tb_div_nr_param.sv
// tb/tb_div_nr_param.sv - directed vector bench for div_nr_param (remainder checks under DIV_REMAINDER_EN)
module tb_div_nr_param;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         e;
        int           lat;
        string        name;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    div_nr_param_if #(.WIDTH(W)) dif ();

    div_nr_param #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (dif.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clock);
        dif.data_operandA = a;
        dif.data_operandB = b;
        dif.is_signed     = s;
        dif.ctrl_DIV      = 1'b1;
        @(posedge clock);
        @(negedge clock);
        dif.ctrl_DIV      = 1'b0;
        dif.data_operandA = ~a;
        dif.data_operandB = ~b;
        dif.is_signed     = ~s;
    endtask

    task automatic watch(input int n, input logic exp_busy_run,
                         output int first, output int pulses, output int busy_err);
        first = 0;
        pulses = 0;
        busy_err = 0;
        for (int i = 1; i <= n; i++) begin
            logic eb;
            @(posedge clock);
            #1;
            eb = exp_busy_run && (i <= W);
            if (dif.data_resultRDY === 1'b1) begin
                pulses++;
                if (first == 0) first = i;
            end
            if (dif.busy !== eb) busy_err++;
        end
    endtask

    vec_t vecs[12];

    initial begin
        int first, pulses, busy_err;

        vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, W+2, "u100_7"};
        vecs[1]  = '{32'hFFFFFF9C,   32'd7,          1'b1, 32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, W+2, "s_m100_7"};
        vecs[2]  = '{32'd100,        32'hFFFFFFF9,   1'b1, 32'hFFFFFFF2,   32'd2,          1'b0, W+2, "s100_m7"};
        vecs[3]  = '{32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 32'd14,         32'hFFFFFFFE,   1'b0, W+2, "s_m100_m7"};
        vecs[4]  = '{32'd5,          32'd0,          1'b0, 32'd0,          32'd5,          1'b1, 1,   "u5_0"};
        vecs[5]  = '{32'hFFFFFFFB,   32'd0,          1'b1, 32'd0,          32'hFFFFFFFB,   1'b1, 1,   "s_m5_0"};
        vecs[6]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0, W+2, "s_min_m1"};
        vecs[7]  = '{32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000,   1'b0, W+2, "u_min_max"};
        vecs[8]  = '{32'd6,          32'd4,          1'b0, 32'd1,          32'd2,          1'b0, W+2, "u6_4"};
        vecs[9]  = '{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b0, W+2, "u_max_1"};
        vecs[10] = '{32'd7,          32'd100,        1'b0, 32'd0,          32'd7,          1'b0, W+2, "u7_100"};
        vecs[11] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'd1,          32'd0,          1'b0, W+2, "u_max_max"};

        dif.ctrl_DIV      = 1'b0;
        dif.ctrl_MULT     = 1'b0;
        dif.is_signed     = 1'b0;
        dif.data_operandA = '0;
        dif.data_operandB = '0;

        repeat (2) @(posedge clock);
        #1;
        check("reset.result", dif.data_result, 0);
        check("reset.exc", dif.data_exception, 0);
        check("reset.rdy", dif.data_resultRDY, 0);
        check("reset.busy", dif.busy, 0);
`ifdef DIV_REMAINDER_EN
        check("reset.rem", dif.data_remainder, 0);
`endif
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].s);
            watch(W + 6, ~vecs[i].e, first, pulses, busy_err);
            check($sformatf("%s.lat", vecs[i].name), first, vecs[i].lat);
            check($sformatf("%s.pulses", vecs[i].name), pulses, 1);
            check($sformatf("%s.busy", vecs[i].name), busy_err, 0);
            check($sformatf("%s.q", vecs[i].name), dif.data_result, vecs[i].q);
            check($sformatf("%s.exc", vecs[i].name), dif.data_exception, vecs[i].e);
`ifdef DIV_REMAINDER_EN
            check($sformatf("%s.rem", vecs[i].name), dif.data_remainder, vecs[i].r);
`endif
        end

        // Abort with ctrl_MULT ten cycles in: no pulse, previous result kept.
        start_op(32'd100, 32'd7, 1'b0);
        watch(9, 1'b1, first, pulses, busy_err);
        @(negedge clock);
        dif.ctrl_MULT = 1'b1;
        @(posedge clock);
        #1;
        check("abort.busy", dif.busy, 0);
        @(negedge clock);
        dif.ctrl_MULT = 1'b0;
        watch(W + 4, 1'b0, first, pulses, busy_err);
        check("abort.pulses", pulses, 0);
        check("abort.q", dif.data_result, 1);
`ifdef DIV_REMAINDER_EN
        check("abort.rem", dif.data_remainder, 0);
`endif

        // Restart with new operands ten cycles into a divide.
        start_op(32'd100, 32'd7, 1'b0);
        watch(9, 1'b1, first, pulses, busy_err);
        check("restart.early_pulses", pulses, 0);
        start_op(32'd9, 32'd3, 1'b0);
        watch(W + 6, 1'b1, first, pulses, busy_err);
        check("restart.lat", first, W + 2);
        check("restart.pulses", pulses, 1);
        check("restart.q", dif.data_result, 3);
`ifdef DIV_REMAINDER_EN
        check("restart.rem", dif.data_remainder, 0);
`endif

        // Asynchronous reset mid-operation.
        start_op(32'd100, 32'd7, 1'b0);
        watch(14, 1'b1, first, pulses, busy_err);
        #2;
        reset = 1'b1;
        #1;
        check("midrst.result", dif.data_result, 0);
        check("midrst.exc", dif.data_exception, 0);
        check("midrst.rdy", dif.data_resultRDY, 0);
        check("midrst.busy", dif.busy, 0);
`ifdef DIV_REMAINDER_EN
        check("midrst.rem", dif.data_remainder, 0);
`endif
        @(negedge clock);
        reset = 1'b0;
        watch(W + 4, 1'b0, first, pulses, busy_err);
        check("midrst.pulses", pulses, 0);
        start_op(32'd6, 32'd4, 1'b0);
        watch(W + 6, 1'b1, first, pulses, busy_err);
        check("post_rst.lat", first, W + 2);
        check("post_rst.q", dif.data_result, 1);
`ifdef DIV_REMAINDER_EN
        check("post_rst.rem", dif.data_remainder, 2);
`endif

        // ctrl_MULT and ctrl_DIV together: no divide starts.
        @(negedge clock);
        dif.data_operandA = 32'd100;
        dif.data_operandB = 32'd7;
        dif.is_signed     = 1'b0;
        dif.ctrl_DIV      = 1'b1;
        dif.ctrl_MULT     = 1'b1;
        @(posedge clock);
        #1;
        check("both.busy", dif.busy, 0);
        @(negedge clock);
        dif.ctrl_DIV  = 1'b0;
        dif.ctrl_MULT = 1'b0;
        watch(W + 4, 1'b0, first, pulses, busy_err);
        check("both.pulses", pulses, 0);
        check("both.busy_window", busy_err, 0);
        check("both.q", dif.data_result, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
